shift_left_ctrl: RTL and testbench
==================================

// Module: shift_left_ctrl
// PURPOSE
//  Request/response front end for the 20-bit shift_left unit; sits directly upstream of it and consumes its result.
//  Accepts a 20-bit operand and a 5-bit shift amount (0..31). Splits amounts beyond the shifter's 4-bit range
//  into successive passes of at most 15, and returns the result with zero and carry-out flags.
// PARAMETERS
//  WIDTH    20  operand/result width
//  AMT_W    5   request shift-amount width
//  SH_AMT_W 4   shifter amount width; max per-pass shift = 2**SH_AMT_W-1 = 15
//  SH_LAT   1   shifter latency in cycles from sh_a/sh_b to valid sh_c (0 = combinational)
// PORTS
//  clk        in   1      clock, all logic on posedge
//  rst        in   1      synchronous, active-high reset
//  req_valid  in   1      request present
//  req_ready  out  1      block can accept a request
//  req_data   in   WIDTH  operand
//  req_amt    in   AMT_W  shift-left amount
//  sh_a       out  WIDTH  operand to shifter (shift_left .a)
//  sh_b       out  4      per-pass amount to shifter (shift_left .b)
//  sh_c       in   WIDTH  shifter result (shift_left .c)
//  rsp_valid  out  1      result present
//  rsp_ready  in   1      consumer takes result
//  rsp_data   out  WIDTH  req_data << req_amt, truncated to WIDTH
//  rsp_zero   out  1      rsp_data == 0
//  rsp_carry  out  1      last bit shifted out: req_data[WIDTH-amt] for 1<=amt<=WIDTH, else 0
// BEHAVIOUR
//  - Reset: state IDLE; req_ready=0 while rst is high, then 1. rsp_valid, rsp_data, rsp_zero, rsp_carry, sh_a, sh_b = 0.
//  - FSM IDLE -> ISSUE -> DONE -> IDLE. req_ready=1 only in IDLE.
//  - IDLE: on req_valid&req_ready, latch work=req_data, rem=req_amt, and compute carry from req_data.
//    If amt==0 -> DONE with data=req_data.
//    If amt>=WIDTH -> DONE with data=0; shifter is not exercised.
//    Otherwise -> ISSUE.
//  - ISSUE: sh_a=work, sh_b=min(rem,15), held stable for the whole pass. A wait counter runs 0..SH_LAT.
//    At count==SH_LAT: work<=sh_c, rem<=rem-sh_b. If the new rem==0 -> DONE, else start the next pass
//    (counter cleared, new sh_a/sh_b next cycle).
//    With SH_LAT=0, sh_c is captured in the first ISSUE cycle.
//  - Outside ISSUE: sh_b=0 and sh_a holds its last value.
//  - DONE: rsp_valid=1; rsp_data/zero/carry stable until rsp_ready. On the handshake -> IDLE; req_ready rises the cycle after.
//    No request/response bypass: throughput is at most one op per (passes*(SH_LAT+1)+2) cycles.
//  - Latency from accept edge T to rsp_valid:
//    amt 0 or >=20: T+1; amt 1..15: T+2+SH_LAT; amt 16..19: T+3+2*SH_LAT.
//  - req_valid in non-IDLE states is ignored; the request is not consumed.
//  - rst asserted in any state: the op is abandoned, no response is issued, and the block is in IDLE with outputs at reset values
//    the cycle after.
//  - Width: all shifts are logical and fill with zeros; bits shifted past bit WIDTH-1 are discarded.
// TESTING (SH_LAT=1; bench drives sh_c from a registered shift_left model)
//  1. data=0x0000A, amt=1 -> rsp_data=0x00014, zero=0, carry=0; sh_b=1 for one pass; rsp_valid at T+3.
//  2. data=0x00001, amt=19 -> sh_b sequence 15 then 4; rsp_data=0x80000, carry=0; rsp_valid at T+5.
//  3. data=0xFFFFF, amt=20 -> rsp_data=0, zero=1, carry=1; rsp_valid at T+1; sh_b stays 0.
//  4. data=0x12345, amt=0 -> rsp_data=0x12345, carry=0, zero=0; rsp_valid at T+1.
//  5. rsp_ready low 4 cycles after rsp_valid -> rsp_* held stable, req_ready=0, a pending req_valid is not
//     accepted until 1 cycle after the handshake.
//  6. rst pulsed during the second pass of amt=18 -> no rsp_valid; req_ready=1 after release;
//     the next op (0x00003, amt=2) returns 0x0000C.

Source files
------------

// File: rtl/shift_left_ctrl.sv
// Request/response front end for the shift_left unit: splits large shifts into passes, adds zero/carry flags.
// Latency: amt 0 or >=WIDTH -> 1 cycle; otherwise passes*(SH_LAT+1)+1 cycles from accept to rsp_valid.
// Backpressure: one op in flight; req_ready only in IDLE, result held in DONE until rsp_ready.
module shift_left_ctrl #(
   parameter int WIDTH    = 20,
   parameter int AMT_W    = 5,
   parameter int SH_AMT_W = 4,
   parameter int SH_LAT   = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [WIDTH-1:0]    req_data,
   input  logic [AMT_W-1:0]    req_amt,
   output logic [WIDTH-1:0]    sh_a,
   output logic [SH_AMT_W-1:0] sh_b,
   input  logic [WIDTH-1:0]    sh_c,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [WIDTH-1:0]    rsp_data,
   output logic                rsp_zero,
   output logic                rsp_carry
);

   localparam int               CNT_W     = (SH_LAT < 1) ? 1 : $clog2(SH_LAT + 1);
   localparam logic [AMT_W-1:0] PASS_MAX  = AMT_W'((1 << SH_AMT_W) - 1);
   localparam logic [AMT_W-1:0] AMT_WIDTH = AMT_W'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SH_LAT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   logic [AMT_W-1:0] rem;        // shift amount still to be applied
   logic [CNT_W-1:0] cnt;        // cycles spent waiting on the current pass
   logic             carry_q;    // carry-out, known at accept time
   logic [WIDTH:0]   carry_mask;
   logic             carry_in;
   logic [AMT_W-1:0] rem_next;

   // Largest single pass the shifter can do is PASS_MAX; clamp the remainder to it.
   function automatic logic [SH_AMT_W-1:0] pass_amt(input logic [AMT_W-1:0] r);
      return (r > PASS_MAX) ? PASS_MAX[SH_AMT_W-1:0] : r[SH_AMT_W-1:0];
   endfunction

   // Carry is the bit that lands on position WIDTH after the full shift: select it with a
   // mask walked down from bit WIDTH, which naturally gives 0 for amt 0 and amt > WIDTH.
   always_comb begin
      carry_mask = {1'b1, {WIDTH{1'b0}}} >> req_amt;
      carry_in   = |({1'b0, req_data} & carry_mask);
      rem_next   = rem - AMT_W'(sh_b);
   end

   // Accept only when idle and not being reset.
   assign req_ready = (state == IDLE) && !rst;

   // Control FSM: accept, iterate passes through the shifter, hold the response.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rem       <= '0;
         cnt       <= '0;
         carry_q   <= 1'b0;
         sh_a      <= '0;
         sh_b      <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_zero  <= 1'b0;
         rsp_carry <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  carry_q <= carry_in;
                  if (req_amt == '0) begin
                     state     <= DONE;
                     rsp_valid <= 1'b1;
                     rsp_data  <= req_data;
                     rsp_zero  <= (req_data == '0);
                     rsp_carry <= carry_in;
                  end else if (req_amt >= AMT_WIDTH) begin
                     // Everything shifts out; the shifter is not needed.
                     state     <= DONE;
                     rsp_valid <= 1'b1;
                     rsp_data  <= '0;
                     rsp_zero  <= 1'b1;
                     rsp_carry <= carry_in;
                  end else begin
                     state <= ISSUE;
                     sh_a  <= req_data;
                     sh_b  <= pass_amt(req_amt);
                     rem   <= req_amt;
                     cnt   <= '0;
                  end
               end
            end
            ISSUE: begin
               if (cnt == CNT_LAST) begin
                  if (rem_next == '0) begin
                     // Last pass: sh_a keeps its value, sh_b drops to 0.
                     state     <= DONE;
                     rem       <= '0;
                     sh_b      <= '0;
                     rsp_valid <= 1'b1;
                     rsp_data  <= sh_c;
                     rsp_zero  <= (sh_c == '0);
                     rsp_carry <= carry_q;
                  end else begin
                     sh_a <= sh_c;
                     sh_b <= pass_amt(rem_next);
                     rem  <= rem_next;
                     cnt  <= '0;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            DONE: begin
               if (rsp_ready) begin
                  state     <= IDLE;
                  rsp_valid <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_left_ctrl.sv
// Directed bench for shift_left_ctrl with a registered shift_left model behind it.
// Each scenario task drives its own stimulus and checks results inline.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
module tb_shift_left_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [19:0] req_data = '0;
   logic [4:0]  req_amt = '0;
   logic [19:0] sh_a;
   logic [3:0]  sh_b;
   logic [19:0] sh_c = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [19:0] rsp_data;
   logic        rsp_zero;
   logic        rsp_carry;

   int          total = 0;
   int          bad = 0;
   int          shb_log[$];
   logic [19:0] sha_log[$];

   shift_left_ctrl #(
      .WIDTH(20), .AMT_W(5), .SH_AMT_W(4), .SH_LAT(1)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_data(req_data), .req_amt(req_amt),
      .sh_a(sh_a), .sh_b(sh_b), .sh_c(sh_c),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_carry(rsp_carry)
   );

   always #5 clk = ~clk;

   // shift_left unit with one cycle of latency
   always @(posedge clk) sh_c <= sh_a << sh_b;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Present one request for a single edge (the accept edge).
   task automatic issue(input logic [19:0] d, input logic [4:0] a);
      req_data  = d;
      req_amt   = a;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
   endtask

   // n = edge index (relative to accept) at which rsp_valid is first sampled high.
   task automatic wait_rsp(output int n);
      n = 1;
      shb_log.delete();
      sha_log.delete();
      while (rsp_valid !== 1'b1 && n < 40) begin
         shb_log.push_back(int'(sh_b));
         sha_log.push_back(sh_a);
         tick();
         n++;
      end
   endtask

   task automatic release_rsp;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick();
      tick();
      total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rst_req_ready got=%b want=0", req_ready); end
      total++; if ({rsp_valid, rsp_zero, rsp_carry, rsp_data} !== 23'h0) begin
         bad++; $display("FAIL rst_rsp got v=%b z=%b c=%b d=%h want all 0", rsp_valid, rsp_zero, rsp_carry, rsp_data); end
      total++; if ({sh_a, sh_b} !== 24'h0) begin bad++; $display("FAIL rst_sh got a=%h b=%0d want 0", sh_a, sh_b); end
      rst = 1'b0;
      #1;
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b want=1", req_ready); end
      tick();
   endtask

   task automatic test_one_pass;
      int n;
      issue(20'h0000A, 5'd1);
      wait_rsp(n);
      total++; if (n !== 3) begin bad++; $display("FAIL t1_latency got=T+%0d want=T+3", n); end
      total++; if ({rsp_data, rsp_zero, rsp_carry} !== {20'h00014, 1'b0, 1'b0}) begin
         bad++; $display("FAIL t1_result got d=%h z=%b c=%b want d=00014 z=0 c=0", rsp_data, rsp_zero, rsp_carry); end
      total++; if (shb_log.size() !== 2 || shb_log[0] !== 1 || shb_log[1] !== 1) begin
         bad++; $display("FAIL t1_sh_b got n=%0d first=%0d want two samples of 1", shb_log.size(), shb_log[0]); end
      total++; if (sha_log[0] !== 20'h0000A || sh_b !== 4'd0) begin
         bad++; $display("FAIL t1_sh_a got a=%h b_done=%0d want a=0000a b_done=0", sha_log[0], sh_b); end
      release_rsp();
      total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
         bad++; $display("FAIL t1_handshake got v=%b rdy=%b want v=0 rdy=1", rsp_valid, req_ready); end
   endtask

   task automatic test_two_pass;
      int n;
      issue(20'h00001, 5'd19);
      wait_rsp(n);
      total++; if (n !== 5) begin bad++; $display("FAIL t2_latency got=T+%0d want=T+5", n); end
      total++; if ({rsp_data, rsp_zero, rsp_carry} !== {20'h80000, 1'b0, 1'b0}) begin
         bad++; $display("FAIL t2_result got d=%h z=%b c=%b want d=80000 z=0 c=0", rsp_data, rsp_zero, rsp_carry); end
      total++; if (shb_log.size() !== 4 || shb_log[0] !== 15 || shb_log[1] !== 15 || shb_log[2] !== 4 || shb_log[3] !== 4) begin
         bad++; $display("FAIL t2_sh_b got %0d,%0d,%0d,%0d want 15,15,4,4", shb_log[0], shb_log[1], shb_log[2], shb_log[3]); end
      total++; if (sha_log[2] !== 20'h08000) begin bad++; $display("FAIL t2_pass2_sh_a got=%h want=08000", sha_log[2]); end
      release_rsp();
   endtask

   task automatic test_far_shift;
      int n;
      issue(20'hFFFFF, 5'd20);
      wait_rsp(n);
      total++; if (n !== 1) begin bad++; $display("FAIL t3_latency got=T+%0d want=T+1", n); end
      total++; if ({rsp_data, rsp_zero, rsp_carry} !== {20'h00000, 1'b1, 1'b1}) begin
         bad++; $display("FAIL t3_result got d=%h z=%b c=%b want d=00000 z=1 c=1", rsp_data, rsp_zero, rsp_carry); end
      total++; if (sh_b !== 4'd0) begin bad++; $display("FAIL t3_sh_b got=%0d want=0", sh_b); end
      release_rsp();
      issue(20'hFFFFF, 5'd31);
      wait_rsp(n);
      total++; if (n !== 1 || {rsp_data, rsp_zero, rsp_carry} !== {20'h00000, 1'b1, 1'b0}) begin
         bad++; $display("FAIL amt31 got n=%0d d=%h z=%b c=%b want n=1 d=00000 z=1 c=0", n, rsp_data, rsp_zero, rsp_carry); end
      release_rsp();
   endtask

   task automatic test_zero_amt;
      int n;
      issue(20'h12345, 5'd0);
      wait_rsp(n);
      total++; if (n !== 1) begin bad++; $display("FAIL t4_latency got=T+%0d want=T+1", n); end
      total++; if ({rsp_data, rsp_zero, rsp_carry} !== {20'h12345, 1'b0, 1'b0}) begin
         bad++; $display("FAIL t4_result got d=%h z=%b c=%b want d=12345 z=0 c=0", rsp_data, rsp_zero, rsp_carry); end
      release_rsp();
   endtask

   task automatic test_flags;
      int n;
      // top bit shifted out through the shifter: zero result with carry set
      issue(20'h80000, 5'd1);
      wait_rsp(n);
      total++; if (n !== 3 || {rsp_data, rsp_zero, rsp_carry} !== {20'h00000, 1'b1, 1'b1}) begin
         bad++; $display("FAIL carry_zero got n=%0d d=%h z=%b c=%b want n=3 d=00000 z=1 c=1", n, rsp_data, rsp_zero, rsp_carry); end
      release_rsp();
      // largest single pass
      issue(20'h00001, 5'd15);
      wait_rsp(n);
      total++; if (n !== 3 || rsp_data !== 20'h08000 || shb_log.size() !== 2 || shb_log[0] !== 15) begin
         bad++; $display("FAIL amt15 got n=%0d d=%h passes=%0d b=%0d want n=3 d=08000 passes=2 b=15", n, rsp_data, shb_log.size(), shb_log[0]); end
      release_rsp();
      // smallest two-pass amount, carry from bit 4, bit 4 itself lost
      issue(20'h00018, 5'd16);
      wait_rsp(n);
      total++; if (n !== 5 || {rsp_data, rsp_zero, rsp_carry} !== {20'h80000, 1'b0, 1'b1}) begin
         bad++; $display("FAIL amt16 got n=%0d d=%h z=%b c=%b want n=5 d=80000 z=0 c=1", n, rsp_data, rsp_zero, rsp_carry); end
      total++; if (shb_log[2] !== 1) begin bad++; $display("FAIL amt16_pass2 got=%0d want=1", shb_log[2]); end
      release_rsp();
   endtask

   task automatic test_backpressure;
      int n;
      logic stable;
      issue(20'h00005, 5'd3);
      wait_rsp(n);
      total++; if (n !== 3 || rsp_data !== 20'h00028) begin
         bad++; $display("FAIL t5_first got n=%0d d=%h want n=3 d=00028", n, rsp_data); end
      req_data  = 20'h00001;
      req_amt   = 5'd1;
      req_valid = 1'b1;
      stable = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (rsp_valid !== 1'b1 || rsp_data !== 20'h00028 || rsp_zero !== 1'b0 ||
             rsp_carry !== 1'b0 || req_ready !== 1'b0) stable = 1'b0;
      end
      total++; if (stable !== 1'b1) begin bad++; $display("FAIL t5_hold got stable=%b want=1", stable); end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
         bad++; $display("FAIL t5_after_hs got v=%b rdy=%b want v=0 rdy=1", rsp_valid, req_ready); end
      tick();
      req_valid = 1'b0;
      total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL t5_pending_accept got rdy=%b want=0", req_ready); end
      wait_rsp(n);
      total++; if (n !== 3 || rsp_data !== 20'h00002) begin
         bad++; $display("FAIL t5_second got n=%0d d=%h want n=3 d=00002", n, rsp_data); end
      release_rsp();
   endtask

   task automatic test_reset_mid;
      int  n;
      logic quiet;
      issue(20'h00001, 5'd18);
      tick();
      tick();
      total++; if (sh_b !== 4'd3) begin bad++; $display("FAIL t6_second_pass got b=%0d want=3", sh_b); end
      rst = 1'b1;
      tick();
      total++; if (rsp_valid !== 1'b0 || sh_b !== 4'd0 || sh_a !== 20'h0 || req_ready !== 1'b0) begin
         bad++; $display("FAIL t6_in_reset got v=%b a=%h b=%0d rdy=%b want all 0", rsp_valid, sh_a, sh_b, req_ready); end
      rst = 1'b0;
      #1;
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL t6_release_ready got=%b want=1", req_ready); end
      quiet = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (rsp_valid !== 1'b0) quiet = 1'b0;
      end
      total++; if (quiet !== 1'b1) begin bad++; $display("FAIL t6_no_rsp got quiet=%b want=1", quiet); end
      issue(20'h00003, 5'd2);
      wait_rsp(n);
      total++; if (n !== 3 || {rsp_data, rsp_zero, rsp_carry} !== {20'h0000C, 1'b0, 1'b0}) begin
         bad++; $display("FAIL t6_next_op got n=%0d d=%h z=%b c=%b want n=3 d=0000c z=0 c=0", n, rsp_data, rsp_zero, rsp_carry); end
      release_rsp();
   endtask

   initial begin
      test_reset();
      test_one_pass();
      test_two_pass();
      test_far_shift();
      test_zero_amt();
      test_flags();
      test_backpressure();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
